// File: rtl/ram_rw_master_if.sv
// ram_rw memory bus between the core-side initiator and the external responder.
// Single outstanding transaction: cen pulses for one cycle, ready closes the access.
interface ram_rw_master_if;
   logic        ram_rw_cen_o;
   logic        ram_rw_wen_o;
   logic [63:0] ram_rw_addr_o;
   logic [63:0] ram_rw_wdata_o;
   logic [7:0]  ram_rw_wmask_o;
   logic [2:0]  ram_rw_size_o;
   logic        ram_rw_ready_i;
   logic [63:0] ram_rw_data_i;

   modport master (
      output ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
             ram_rw_wmask_o, ram_rw_size_o,
      input  ram_rw_ready_i, ram_rw_data_i
   );

   modport slave (
      input  ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
             ram_rw_wmask_o, ram_rw_size_o,
      output ram_rw_ready_i, ram_rw_data_i
   );
endinterface

// File: rtl/ram_rw_master.sv
// Arbitrates IFU fetches and LSU loads/stores onto the single-port ram_rw bus,
// aligning store lanes and extracting/extending load data. One transaction in flight.
//
// Handshakes: a requester raises req and holds it with stable fields until gnt
// (combinational, IDLE only). ram_rw: cen is a one-cycle strobe; the responder
// answers with ready plus data in one cycle, and ready is only sampled in WAIT.
module ram_rw_master #(
   parameter bit          PRIO_LS     = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           if_req_i,
   input  logic [63:0]    if_addr_i,
   output logic           if_gnt_o,
   output logic           if_valid_o,
   output logic [31:0]    if_rdata_o,
   output logic           if_err_o,
   input  logic           ls_req_i,
   input  logic           ls_wen_i,
   input  logic [63:0]    ls_addr_i,
   input  logic [2:0]     ls_size_i,
   input  logic [63:0]    ls_wdata_i,
   output logic           ls_gnt_o,
   output logic           ls_valid_o,
   output logic [63:0]    ls_rdata_o,
   output logic           ls_err_o,
   ram_rw_master_if.master ram,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int unsigned   CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

   function automatic logic misaligned(input logic [63:0] addr, input logic [1:0] sz);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return addr[0];
         2'd2:    return |addr[1:0];
         default: return |addr[2:0];
      endcase
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
      case (sz)
         2'd0:    return 8'h01 << off;
         2'd1:    return 8'h03 << off;
         2'd2:    return 8'h0F << off;
         default: return 8'hFF;
      endcase
   endfunction

   // sz[2] selects zero-extension; doubleword ignores it.
   function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] off,
                                               input logic [2:0] sz);
      logic [63:0] x;
      x = word >> {off, 3'b000};
      case (sz[1:0])
         2'd0:    return sz[2] ? {56'd0, x[7:0]}  : {{56{x[7]}},  x[7:0]};
         2'd1:    return sz[2] ? {48'd0, x[15:0]} : {{48{x[15]}}, x[15:0]};
         2'd2:    return sz[2] ? {32'd0, x[31:0]} : {{32{x[31]}}, x[31:0]};
         default: return x;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          own_ls_q;
   logic          wen_q;
   logic [2:0]    off_q;
   logic [2:0]    size_q;

   logic          pick_ls, pick_if, grant, req_mis, req_store;
   logic [63:0]   sel_addr;
   logic [1:0]    sel_sz;
   logic          resp_go, resp_ls, resp_err;
   logic [63:0]   resp_ls_data;
   logic [31:0]   resp_if_data;

   always_comb begin
      pick_ls   = ls_req_i && (PRIO_LS || !if_req_i);
      pick_if   = if_req_i && !pick_ls;
      grant     = rst_n && (state_q == IDLE) && (pick_ls || pick_if);
      if_gnt_o  = grant && pick_if;
      ls_gnt_o  = grant && pick_ls;
      sel_addr  = pick_ls ? ls_addr_i : if_addr_i;
      sel_sz    = pick_ls ? ls_size_i[1:0] : 2'd2;
      req_mis   = misaligned(sel_addr, sel_sz);
      req_store = pick_ls && ls_wen_i;
   end

   always_comb begin
      state_d  = state_q;
      resp_go  = 1'b0;
      resp_ls  = own_ls_q;
      resp_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               if (req_mis) begin
                  state_d  = RESP;
                  resp_go  = 1'b1;
                  resp_ls  = pick_ls;
                  resp_err = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ:  state_d = WAIT;
         WAIT: begin
            if (ram.ram_rw_ready_i) begin
               state_d = RESP;
               resp_go = 1'b1;
            end else if (cnt_q == TMAX) begin
               state_d  = RESP;
               resp_go  = 1'b1;
               resp_err = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      resp_ls_data = '0;
      resp_if_data = '0;
      if (!resp_err) begin
         if (!wen_q) resp_ls_data = load_extend(ram.ram_rw_data_i, off_q, size_q);
         resp_if_data = off_q[2] ? ram.ram_rw_data_i[63:32] : ram.ram_rw_data_i[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Bus outputs are set at the grant edge so they are valid exactly in REQ.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q              <= '0;
         own_ls_q           <= 1'b0;
         wen_q              <= 1'b0;
         off_q              <= '0;
         size_q             <= '0;
         ram.ram_rw_cen_o   <= 1'b0;
         ram.ram_rw_wen_o   <= 1'b0;
         ram.ram_rw_addr_o  <= '0;
         ram.ram_rw_wdata_o <= '0;
         ram.ram_rw_wmask_o <= '0;
         ram.ram_rw_size_o  <= '0;
         if_valid_o         <= 1'b0;
         if_rdata_o         <= '0;
         if_err_o           <= 1'b0;
         ls_valid_o         <= 1'b0;
         ls_rdata_o         <= '0;
         ls_err_o           <= 1'b0;
      end else begin
         ram.ram_rw_cen_o   <= 1'b0;
         ram.ram_rw_wen_o   <= 1'b0;
         ram.ram_rw_addr_o  <= '0;
         ram.ram_rw_wdata_o <= '0;
         ram.ram_rw_wmask_o <= '0;
         ram.ram_rw_size_o  <= '0;
         if_valid_o         <= 1'b0;
         ls_valid_o         <= 1'b0;
         cnt_q              <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
         if (grant) begin
            own_ls_q <= pick_ls;
            wen_q    <= req_store;
            off_q    <= sel_addr[2:0];
            size_q   <= pick_ls ? ls_size_i : 3'b110;
            if (!req_mis) begin
               ram.ram_rw_cen_o  <= 1'b1;
               ram.ram_rw_wen_o  <= req_store;
               ram.ram_rw_addr_o <= {sel_addr[63:3], 3'b000};
               ram.ram_rw_size_o <= {1'b0, sel_sz};
               if (req_store) begin
                  ram.ram_rw_wdata_o <= ls_wdata_i << {ls_addr_i[2:0], 3'b000};
                  ram.ram_rw_wmask_o <= lane_mask(ls_size_i[1:0], ls_addr_i[2:0]);
               end
            end
         end
         if (resp_go) begin
            if (resp_ls) begin
               ls_valid_o <= 1'b1;
               ls_err_o   <= resp_err;
               ls_rdata_o <= resp_ls_data;
            end else begin
               if_valid_o <= 1'b1;
               if_err_o   <= resp_err;
               if_rdata_o <= resp_if_data;
            end
         end
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_rw_master.sv
// Bench for ram_rw_master: bench plays IFU, LSU and responder; a transaction-level
// model predicts bus beats and responses, a negedge process compares every cycle.
module tb_ram_rw_master;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i, if_gnt_o, if_valid_o, if_err_o;
   logic [63:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        ls_req_i, ls_wen_i, ls_gnt_o, ls_valid_o, ls_err_o;
   logic [63:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
   logic [2:0]  ls_size_i;
   logic [1:0]  dbg_state;

   ram_rw_master_if bus ();

   ram_rw_master #(.PRIO_LS(1'b1), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_gnt_o   (if_gnt_o),
      .if_valid_o (if_valid_o),
      .if_rdata_o (if_rdata_o),
      .if_err_o   (if_err_o),
      .ls_req_i   (ls_req_i),
      .ls_wen_i   (ls_wen_i),
      .ls_addr_i  (ls_addr_i),
      .ls_size_i  (ls_size_i),
      .ls_wdata_i (ls_wdata_i),
      .ls_gnt_o   (ls_gnt_o),
      .ls_valid_o (ls_valid_o),
      .ls_rdata_o (ls_rdata_o),
      .ls_err_o   (ls_err_o),
      .ram        (bus),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // bus beat: {wen, addr, wdata, wmask, size}; response: {is_ls, err, data}
   logic [139:0] bus_q[$];
   logic [65:0]  exp_q[$];
   logic [139:0] last_beat;

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---- behavioural model: byte-by-byte view of the access ----
   function automatic int nbytes(input bit is_ls, input logic [2:0] size);
      return is_ls ? (1 << size[1:0]) : 4;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] word, input logic [63:0] addr,
                                          input logic [2:0] size);
      int n, off;
      logic [63:0] v;
      n = 1 << size[1:0];
      off = int'(addr[2:0]);
      v = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!size[2] && n < 8 && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] m_mask(input logic [63:0] addr, input logic [2:0] size);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < (1 << size[1:0]); i++)
         if (int'(addr[2:0]) + i < 8) m[int'(addr[2:0]) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] wd);
      logic [63:0] w;
      int off;
      off = int'(addr[2:0]);
      w = '0;
      for (int j = 0; j < 8; j++)
         if (j >= off) w[8*j +: 8] = wd[8*(j-off) +: 8];
      return w;
   endfunction

   // ---- per-cycle compare ----
   always @(negedge clk) begin
      logic [139:0] eb, ab;
      logic [65:0]  er, ar;
      if (bus.ram_rw_cen_o) begin
         last_beat = {bus.ram_rw_wen_o, bus.ram_rw_addr_o, bus.ram_rw_wdata_o,
                      bus.ram_rw_wmask_o, bus.ram_rw_size_o};
         if (bus_q.size() == 0) begin
            chk("unexpected_cen", 1, 0);
         end else begin
            eb = bus_q.pop_front();
            ab = {bus.ram_rw_wen_o, bus.ram_rw_addr_o,
                  eb[139] ? bus.ram_rw_wdata_o : 64'd0,
                  eb[139] ? bus.ram_rw_wmask_o : 8'd0, bus.ram_rw_size_o};
            chk("bus_beat", 144'(ab), 144'(eb));
         end
      end else begin
         chk("bus_idle_zero", 144'({bus.ram_rw_wen_o, bus.ram_rw_addr_o, bus.ram_rw_wdata_o,
                                    bus.ram_rw_wmask_o, bus.ram_rw_size_o}), 0);
      end
      if (if_valid_o && ls_valid_o) begin
         chk("dual_valid", 1, 0);
      end else if (if_valid_o || ls_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            er = exp_q.pop_front();
            ar = ls_valid_o ? {1'b1, ls_err_o, ls_rdata_o} : {1'b0, if_err_o, 32'd0, if_rdata_o};
            chk("response", 144'(ar), 144'(er));
         end
      end
   end

   // ---- driver: one request, responder answers delay cycles into WAIT (>=50: never) ----
   task automatic access(input bit is_ls, input bit wen, input logic [63:0] addr,
                         input logic [2:0] size, input logic [63:0] wd,
                         input logic [63:0] rd, input int delay);
      int n, g, c, v, exp_v;
      bit mis, tmo, st;
      logic [63:0] ld, rdat;
      n   = nbytes(is_ls, size);
      mis = (int'(addr[2:0]) % n) != 0;
      tmo = !mis && delay >= TMO;
      st  = is_ls && wen;
      if (!mis)
         bus_q.push_back({st, addr[63:3], 3'b000, st ? m_wdata(addr, wd) : 64'd0,
                          st ? m_mask(addr, size) : 8'd0,
                          is_ls ? {1'b0, size[1:0]} : 3'd2});
      if (is_ls) rdat = (mis || tmo || st) ? 64'd0 : m_load(rd, addr, size);
      else begin
         ld   = m_load(rd, addr, 3'b110);
         rdat = (mis || tmo) ? 64'd0 : {32'd0, ld[31:0]};
      end
      exp_q.push_back({is_ls, mis || tmo, rdat});
      exp_v = mis ? 1 : (tmo ? 2 + TMO : 3 + delay);

      g = -1; c = -1; v = -1;
      @(posedge clk); #1;
      if (is_ls) begin
         ls_req_i = 1'b1; ls_wen_i = wen; ls_addr_i = addr; ls_size_i = size; ls_wdata_i = wd;
      end else begin
         if_req_i = 1'b1; if_addr_i = addr;
      end
      for (int k = 0; k < TMO + 8; k++) begin
         @(negedge clk);
         if (g < 0 && (if_gnt_o || ls_gnt_o)) g = k;
         if (c < 0 && bus.ram_rw_cen_o) c = k;
         if (v < 0 && (if_valid_o || ls_valid_o)) v = k;
         @(posedge clk); #1;
         if (g >= 0) begin ls_req_i = 1'b0; if_req_i = 1'b0; end
         bus.ram_rw_ready_i = !mis && delay < 50 && (k + 1 == 2 + delay);
         bus.ram_rw_data_i  = rd;
      end
      bus.ram_rw_ready_i = 1'b0;
      chk("gnt_cycle", 144'(g), 0);
      chk("cen_cycle", 144'(c), mis ? 144'(-1) : 144'(1));
      chk("valid_cycle", 144'(v), 144'(exp_v));
   endtask

   task automatic priority_test();
      int lg, ig, lv, iv;
      logic [63:0] d1, d2;
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      bus_q.push_back({1'b0, 64'h8000_0010, 64'd0, 8'd0, 3'd3});
      bus_q.push_back({1'b0, 64'h8000_0020, 64'd0, 8'd0, 3'd2});
      exp_q.push_back({1'b1, 1'b0, d1});
      exp_q.push_back({1'b0, 1'b0, 32'd0, d2[31:0]});
      lg = -1; ig = -1; lv = -1; iv = -1;
      @(posedge clk); #1;
      ls_req_i = 1'b1; ls_wen_i = 1'b0; ls_addr_i = 64'h8000_0010; ls_size_i = 3'd3;
      if_req_i = 1'b1; if_addr_i = 64'h8000_0020;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (lg < 0 && ls_gnt_o) lg = k;
         if (ig < 0 && if_gnt_o) ig = k;
         if (lv < 0 && ls_valid_o) lv = k;
         if (iv < 0 && if_valid_o) iv = k;
         @(posedge clk); #1;
         if (lg >= 0) ls_req_i = 1'b0;
         if (ig >= 0) if_req_i = 1'b0;
         bus.ram_rw_ready_i = (k + 1 == 2) || (k + 1 == 6);
         bus.ram_rw_data_i  = (k + 1 == 2) ? d1 : d2;
      end
      bus.ram_rw_ready_i = 1'b0;
      chk("prio_ls_gnt", 144'(lg), 0);
      chk("prio_if_gnt", 144'(ig), 4);
      chk("prio_ls_valid", 144'(lv), 3);
      chk("prio_if_valid", 144'(iv), 7);
   endtask

   task automatic reset_in_wait_test();
      bus_q.push_back({1'b0, 64'h8000_0018, 64'd0, 8'd0, 3'd3});
      @(posedge clk); #1;
      ls_req_i = 1'b1; ls_wen_i = 1'b0; ls_addr_i = 64'h8000_0018; ls_size_i = 3'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         @(posedge clk); #1;
         if (k == 0) ls_req_i = 1'b0;
         if (k == 2) rst_n = 1'b0;
      end
      @(negedge clk);
      chk("rst_wait_outputs", 144'({if_gnt_o, if_valid_o, if_rdata_o, if_err_o, ls_gnt_o,
                                    ls_valid_o, ls_rdata_o, ls_err_o, bus.ram_rw_cen_o, dbg_state}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.ram_rw_ready_i = 1'b1;
      bus.ram_rw_data_i  = {$urandom, $urandom};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("late_ready_ignored", 144'({bus.ram_rw_cen_o, if_valid_o, ls_valid_o, dbg_state}), 0);
         if (k == 1) begin @(posedge clk); #1; bus.ram_rw_ready_i = 1'b0; end
      end
   endtask

   initial begin
      bit is_ls, wen;
      logic [2:0]  size;
      logic [63:0] addr;
      int n;
      rst_n = 1'b0;
      if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
      ls_req_i = 1'b1; ls_wen_i = 1'b1; ls_addr_i = 64'h8000_0000; ls_size_i = 3'd3;
      ls_wdata_i = '1;
      bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 144'({if_gnt_o, if_valid_o, if_rdata_o, if_err_o, ls_gnt_o,
                                 ls_valid_o, ls_rdata_o, ls_err_o, dbg_state}), 0);
      chk("reset_bus", 144'({bus.ram_rw_cen_o, bus.ram_rw_wen_o, bus.ram_rw_addr_o,
                             bus.ram_rw_wmask_o, bus.ram_rw_size_o}), 0);
      @(posedge clk); #1;
      if_req_i = 1'b0; ls_req_i = 1'b0; bus.ram_rw_ready_i = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      access(1'b0, 1'b0, 64'h8000_0004, 3'd2, 64'd0, 64'h1111_2222_3333_4444, 0);
      chk("fetch_rdata_lit", 144'(if_rdata_o), 144'(32'h1111_2222));
      access(1'b1, 1'b1, 64'h8000_0003, 3'd0, 64'hAB, 64'd0, 0);
      chk("sb_beat_lit", 144'(last_beat),
          144'({1'b1, 64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 3'd0}));
      access(1'b1, 1'b0, 64'h8000_0006, 3'b001, 64'd0, 64'h8001_0000_0000_0000, 0);
      chk("lh_signed_lit", 144'(ls_rdata_o), 144'(64'hFFFF_FFFF_FFFF_8001));
      access(1'b1, 1'b0, 64'h8000_0006, 3'b101, 64'd0, 64'h8001_0000_0000_0000, 1);
      chk("lhu_lit", 144'(ls_rdata_o), 144'(64'h8001));
      priority_test();
      access(1'b1, 1'b0, 64'h8000_0006, 3'd2, 64'd0, 64'd0, 0);
      chk("lw_misaligned_err", 144'(ls_err_o), 1);
      access(1'b1, 1'b0, 64'h8000_0008, 3'd3, 64'd0, 64'h1234, 100);
      chk("timeout_err", 144'({ls_err_o, ls_rdata_o}), 144'({1'b1, 64'd0}));
      access(1'b0, 1'b0, 64'h8000_0008, 3'd2, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, TMO - 1);
      chk("fetch_low_word_lit", 144'({if_err_o, if_rdata_o}), 144'({1'b0, 32'hCAFE_F00D}));
      reset_in_wait_test();

      for (int t = 0; t < 150; t++) begin
         is_ls = 1'($urandom_range(0, 1));
         wen   = is_ls && ($urandom_range(0, 1) == 1);
         size  = 3'($urandom_range(0, 7));
         n     = nbytes(is_ls, size);
         addr  = {32'd0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
         if ($urandom_range(0, 2) != 0) addr = addr & ~64'(n - 1);
         access(is_ls, wen, addr, size, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 5));
      end

      repeat (3) @(posedge clk);
      chk("bus_q_drained", 144'(bus_q.size()), 0);
      chk("exp_q_drained", 144'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
